// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the 8-bit CPU control unit.
// Holds opcode encodings, microstep encodings and control-word bit positions.
// Imported by microcode_decode and control_sequencer.
package cpu_pkg;

  localparam int OPCODE_W = 4;
  localparam int STEP_W   = 3;

  // Opcodes (IR upper nibble). 1001..1101 are undefined and run as NOP.
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Microstep encodings; T0/T1 are the shared fetch, T2..T4 execute.
  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_e;

  // Control-word bit positions.
  localparam int CW_PC_OUT    = 14;
  localparam int CW_PC_INC    = 13;
  localparam int CW_PC_LOAD   = 12;
  localparam int CW_MAR_LOAD  = 11;
  localparam int CW_RAM_OUT   = 10;
  localparam int CW_RAM_IN    = 9;
  localparam int CW_IR_LOAD   = 8;
  localparam int CW_IR_OUT    = 7;
  localparam int CW_A_LOAD    = 6;
  localparam int CW_A_OUT     = 5;
  localparam int CW_B_LOAD    = 4;
  localparam int CW_ALU_OUT   = 3;
  localparam int CW_ALU_SUB   = 2;
  localparam int CW_FLAG_LOAD = 1;
  localparam int CW_OUT_LOAD  = 0;
  localparam int CW_W         = 15;

  typedef logic [CW_W-1:0] ctrl_word_t;

  // Successor step when the current instruction has more active steps.
  function automatic step_e next_step(input step_e s);
    case (s)
      T0:      next_step = T1;
      T1:      next_step = T2;
      T2:      next_step = T3;
      T3:      next_step = T4;
      default: next_step = T0;
    endcase
  endfunction

endpackage

// File: rtl/microcode_decode.sv
// microcode_decode: combinational microcode ROM for the 8-bit CPU.
// Ports: step/opcode/carry/zero in; control word, last_step (instruction ends
// this step) and halt_req (HLT completing this step) out. Zero latency.
module microcode_decode
  import cpu_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  step_e               step_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic                carry_i,
  input  logic                zero_i,
  output ctrl_word_t          cw_o,
  output logic                last_step_o,
  output logic                halt_req_o
);

  logic nop_class;

  // Anything that is not a defined execute opcode finishes with the fetch.
  always_comb begin
    case (opcode_i)
      OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI,
      OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: nop_class = 1'b0;
      default:                              nop_class = 1'b1;
    endcase
  end

  always_comb begin
    cw_o        = '0;
    last_step_o = 1'b0;
    halt_req_o  = 1'b0;
    case (step_i)
      T0: begin
        cw_o[CW_PC_OUT]   = 1'b1;
        cw_o[CW_MAR_LOAD] = 1'b1;
      end
      T1: begin
        cw_o[CW_RAM_OUT] = 1'b1;
        cw_o[CW_IR_LOAD] = 1'b1;
        cw_o[CW_PC_INC]  = 1'b1;
        last_step_o      = nop_class;
      end
      T2: begin
        case (opcode_i)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw_o[CW_IR_OUT]   = 1'b1;
            cw_o[CW_MAR_LOAD] = 1'b1;
          end
          OP_LDI: begin
            cw_o[CW_IR_OUT] = 1'b1;
            cw_o[CW_A_LOAD] = 1'b1;
            last_step_o     = 1'b1;
          end
          OP_JMP: begin
            cw_o[CW_IR_OUT]  = 1'b1;
            cw_o[CW_PC_LOAD] = 1'b1;
            last_step_o      = 1'b1;
          end
          OP_JC: begin
            cw_o[CW_IR_OUT]  = carry_i;
            cw_o[CW_PC_LOAD] = carry_i;
            last_step_o      = 1'b1;
          end
          OP_JZ: begin
            cw_o[CW_IR_OUT]  = zero_i;
            cw_o[CW_PC_LOAD] = zero_i;
            last_step_o      = 1'b1;
          end
          OP_OUT: begin
            cw_o[CW_A_OUT]    = 1'b1;
            cw_o[CW_OUT_LOAD] = 1'b1;
            last_step_o       = 1'b1;
          end
          OP_HLT: begin
            last_step_o = 1'b1;
            halt_req_o  = 1'b1;
          end
          // NOP-class never reaches T2; wrap if it somehow does.
          default: last_step_o = 1'b1;
        endcase
      end
      T3: begin
        case (opcode_i)
          OP_LDA: begin
            cw_o[CW_RAM_OUT] = 1'b1;
            cw_o[CW_A_LOAD]  = 1'b1;
            last_step_o      = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw_o[CW_RAM_OUT] = 1'b1;
            cw_o[CW_B_LOAD]  = 1'b1;
          end
          OP_STA: begin
            cw_o[CW_A_OUT]  = 1'b1;
            cw_o[CW_RAM_IN] = 1'b1;
            last_step_o     = 1'b1;
          end
          default: last_step_o = 1'b1;
        endcase
      end
      T4: begin
        if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
          cw_o[CW_ALU_OUT]   = 1'b1;
          cw_o[CW_A_LOAD]    = 1'b1;
          cw_o[CW_FLAG_LOAD] = 1'b1;
          cw_o[CW_ALU_SUB]   = (opcode_i == OP_SUB);
        end
        last_step_o = 1'b1;
      end
      default: last_step_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: T-state sequencer and strobe gating for the 8-bit CPU.
// Ports: clk/rst/run, IR opcode and flags in; all datapath strobes, halted and
// the current microstep out. Strobes are combinational in the current step.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int STEP_W   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [OPCODE_W-1:0] ir_opcode,
  input  logic                carry_flag,
  input  logic                zero_flag,
  output logic                pc_out,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                mar_load,
  output logic                ram_out,
  output logic                ram_in,
  output logic                ir_load,
  output logic                ir_out,
  output logic                a_load,
  output logic                a_out,
  output logic                b_load,
  output logic                alu_out,
  output logic                alu_sub,
  output logic                flag_load,
  output logic                out_load,
  output logic                halted,
  output logic [STEP_W-1:0]   step
);

  step_e      step_q, step_d;
  logic       halted_q, halted_d;
  ctrl_word_t cw_raw, cw;
  logic       last_step, halt_req;
  logic       active;

  microcode_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .step_i      (step_q),
    .opcode_i    (ir_opcode),
    .carry_i     (carry_flag),
    .zero_i      (zero_flag),
    .cw_o        (cw_raw),
    .last_step_o (last_step),
    .halt_req_o  (halt_req)
  );

  // Strobes only reach the datapath while the step counter actually advances.
  assign active = !rst && run && !halted_q;
  assign cw     = active ? cw_raw : '0;

  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (halted_q) begin
      step_d = T0;
    end else if (run) begin
      if (last_step) begin
        step_d   = T0;
        halted_d = halt_req;
      end else begin
        step_d = next_step(step_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  assign pc_out    = cw[CW_PC_OUT];
  assign pc_inc    = cw[CW_PC_INC];
  assign pc_load   = cw[CW_PC_LOAD];
  assign mar_load  = cw[CW_MAR_LOAD];
  assign ram_out   = cw[CW_RAM_OUT];
  assign ram_in    = cw[CW_RAM_IN];
  assign ir_load   = cw[CW_IR_LOAD];
  assign ir_out    = cw[CW_IR_OUT];
  assign a_load    = cw[CW_A_LOAD];
  assign a_out     = cw[CW_A_OUT];
  assign b_load    = cw[CW_B_LOAD];
  assign alu_out   = cw[CW_ALU_OUT];
  assign alu_sub   = cw[CW_ALU_SUB];
  assign flag_load = cw[CW_FLAG_LOAD];
  assign out_load  = cw[CW_OUT_LOAD];
  assign halted    = halted_q;
  assign step      = STEP_W'(step_q);

`ifndef SYNTHESIS
  // At most one bus driver per step, otherwise the shared bus contends.
  a_bus_onehot : assert property (@(posedge clk)
    $onehot0({pc_out, ram_out, ir_out, a_out, alu_out}));
`endif

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic       clk, rst, run, carry_flag, zero_flag;
  logic [3:0] ir_opcode;
  logic       pc_out, pc_inc, pc_load, mar_load, ram_out, ram_in, ir_load, ir_out;
  logic       a_load, a_out, b_load, alu_out, alu_sub, flag_load, out_load, halted;
  logic [2:0] step;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [14:0] PCO = 15'h4000, PCI = 15'h2000, PCL = 15'h1000, MAR = 15'h0800;
  localparam logic [14:0] RO  = 15'h0400, RI  = 15'h0200, IRL = 15'h0100, IRO = 15'h0080;
  localparam logic [14:0] AL  = 15'h0040, AO  = 15'h0020, BL  = 15'h0010, ALU = 15'h0008;
  localparam logic [14:0] SUB = 15'h0004, FL  = 15'h0002, OL  = 15'h0001;
  localparam logic [14:0] F0 = PCO | MAR;
  localparam logic [14:0] F1 = RO | IRL | PCI;

  wire [14:0] cw = {pc_out, pc_inc, pc_load, mar_load, ram_out, ram_in, ir_load, ir_out,
                    a_load, a_out, b_load, alu_out, alu_sub, flag_load, out_load};

  control_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .ir_opcode(ir_opcode),
    .carry_flag(carry_flag), .zero_flag(zero_flag),
    .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load),
    .ram_out(ram_out), .ram_in(ram_in), .ir_load(ir_load), .ir_out(ir_out),
    .a_load(a_load), .a_out(a_out), .b_load(b_load), .alu_out(alu_out),
    .alu_sub(alu_sub), .flag_load(flag_load), .out_load(out_load),
    .halted(halted), .step(step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1; ir_opcode = 4'h1; carry_flag = 1'b0; zero_flag = 1'b0;
    tick(); tick();
    #1;
    n_checks++;
    if (cw !== 15'h0 || step !== 3'd0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: cw=%h step=%0d halted=%b, expected cw=0000 step=0 halted=0",
               cw, step, halted);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (cw !== F0 || step !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_release: cw=%h step=%0d, expected cw=%h step=0", cw, step, F0);
    end
  endtask

  task automatic test_lda();
    logic [14:0] exp [4];
    exp = '{F0, F1, IRO | MAR, RO | AL};
    ir_opcode = 4'h1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (cw !== exp[i] || step !== 3'(i)) begin
        n_fail++;
        $display("FAIL lda_t%0d: cw=%h step=%0d, expected cw=%h step=%0d", i, cw, step, exp[i], i);
      end
      tick();
    end
    n_checks++;
    if (step !== 3'd0) begin
      n_fail++;
      $display("FAIL lda_wrap: step=%0d, expected 0", step);
    end
  endtask

  task automatic test_add_sub();
    logic [14:0] exp [5];
    for (int k = 0; k < 2; k++) begin
      ir_opcode = (k == 0) ? 4'h2 : 4'h3;
      exp = '{F0, F1, IRO | MAR, RO | BL, (k == 0) ? (ALU | AL | FL) : (ALU | AL | FL | SUB)};
      for (int i = 0; i < 5; i++) begin
        #1;
        n_checks++;
        if (cw !== exp[i] || step !== 3'(i)) begin
          n_fail++;
          $display("FAIL %s_t%0d: cw=%h step=%0d, expected cw=%h step=%0d",
                   (k == 0) ? "add" : "sub", i, cw, step, exp[i], i);
        end
        tick();
      end
      n_checks++;
      if (step !== 3'd0) begin
        n_fail++;
        $display("FAIL %s_wrap: step=%0d, expected 0", (k == 0) ? "add" : "sub", step);
      end
    end
  endtask

  task automatic test_jc();
    logic [14:0] exp [3];
    ir_opcode = 4'h7;
    for (int k = 0; k < 2; k++) begin
      carry_flag = (k == 1);
      exp = '{F0, F1, (k == 1) ? (IRO | PCL) : 15'h0};
      for (int i = 0; i < 3; i++) begin
        #1;
        n_checks++;
        if (cw !== exp[i] || step !== 3'(i)) begin
          n_fail++;
          $display("FAIL jc_c%0d_t%0d: cw=%h step=%0d, expected cw=%h step=%0d",
                   k, i, cw, step, exp[i], i);
        end
        tick();
      end
      n_checks++;
      if (step !== 3'd0) begin
        n_fail++;
        $display("FAIL jc_c%0d_wrap: step=%0d, expected 0", k, step);
      end
    end
    carry_flag = 1'b0;
  endtask

  // Short instructions: opcode, zero flag, cycle count, expected T2 word.
  task automatic test_short_ops();
    logic [3:0]  ops  [7];
    logic        zf   [7];
    int          cyc  [7];
    logic [14:0] t2   [7];
    ops = '{4'h5, 4'h6, 4'hE, 4'h8, 4'h8, 4'hA, 4'h0};
    zf  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    cyc = '{3, 3, 3, 3, 3, 2, 2};
    t2  = '{IRO | AL, IRO | PCL, AO | OL, IRO | PCL, 15'h0, 15'h0, 15'h0};
    for (int k = 0; k < 7; k++) begin
      ir_opcode = ops[k];
      zero_flag = zf[k];
      tick_check_fetch(k);
      if (cyc[k] == 3) begin
        #1;
        n_checks++;
        if (cw !== t2[k] || step !== 3'd2) begin
          n_fail++;
          $display("FAIL op%h_t2: cw=%h step=%0d, expected cw=%h step=2", ops[k], cw, step, t2[k]);
        end
        tick();
      end
      n_checks++;
      if (step !== 3'd0) begin
        n_fail++;
        $display("FAIL op%h_wrap: step=%0d, expected 0", ops[k], step);
      end
    end
    zero_flag = 1'b0;
  endtask

  // Fetch T0/T1 for the short-op loop; inline check of the fetch word.
  task automatic tick_check_fetch(input int k);
    #1;
    n_checks++;
    if (cw !== F0 || step !== 3'd0) begin
      n_fail++;
      $display("FAIL short%0d_t0: cw=%h step=%0d, expected cw=%h step=0", k, cw, step, F0);
    end
    tick();
    #1;
    n_checks++;
    if (cw !== F1 || step !== 3'd1) begin
      n_fail++;
      $display("FAIL short%0d_t1: cw=%h step=%0d, expected cw=%h step=1", k, cw, step, F1);
    end
    tick();
  endtask

  task automatic test_hlt();
    logic [14:0] exp [3];
    exp = '{F0, F1, 15'h0};
    ir_opcode = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (cw !== exp[i] || step !== 3'(i) || halted !== 1'b0) begin
        n_fail++;
        $display("FAIL hlt_t%0d: cw=%h step=%0d halted=%b, expected cw=%h step=%0d halted=0",
                 i, cw, step, halted, exp[i], i);
      end
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      #1;
      n_checks++;
      if (cw !== 15'h0 || step !== 3'd0 || halted !== 1'b1) begin
        n_fail++;
        $display("FAIL hlt_hold%0d: cw=%h step=%0d halted=%b, expected cw=0000 step=0 halted=1",
                 i, cw, step, halted);
      end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (cw !== F0 || step !== 3'd0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL hlt_clear: cw=%h step=%0d halted=%b, expected cw=%h step=0 halted=0",
               cw, step, halted, F0);
    end
  endtask

  task automatic test_sta_pause();
    logic [14:0] exp [3];
    exp = '{F0, F1, IRO | MAR};
    ir_opcode = 4'h4;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (cw !== exp[i] || step !== 3'(i)) begin
        n_fail++;
        $display("FAIL sta_t%0d: cw=%h step=%0d, expected cw=%h step=%0d", i, cw, step, exp[i], i);
      end
      tick();
    end
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (cw !== 15'h0 || step !== 3'd3) begin
        n_fail++;
        $display("FAIL sta_pause%0d: cw=%h step=%0d, expected cw=0000 step=3", i, cw, step);
      end
      tick();
    end
    run = 1'b1;
    #1;
    n_checks++;
    if (cw !== (AO | RI) || step !== 3'd3) begin
      n_fail++;
      $display("FAIL sta_resume: cw=%h step=%0d, expected cw=%h step=3", cw, step, AO | RI);
    end
    tick();
    #1;
    n_checks++;
    if (cw !== F0 || step !== 3'd0) begin
      n_fail++;
      $display("FAIL sta_after: cw=%h step=%0d, expected cw=%h step=0", cw, step, F0);
    end
  endtask

  task automatic test_rst_mid();
    ir_opcode = 4'h2;
    tick(); tick(); tick();
    #1;
    n_checks++;
    if (cw !== (RO | BL) || step !== 3'd3) begin
      n_fail++;
      $display("FAIL rstmid_t3: cw=%h step=%0d, expected cw=%h step=3", cw, step, RO | BL);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (cw !== 15'h0) begin
      n_fail++;
      $display("FAIL rstmid_gate: cw=%h, expected 0000", cw);
    end
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (cw !== F0 || step !== 3'd0) begin
      n_fail++;
      $display("FAIL rstmid_t0: cw=%h step=%0d, expected cw=%h step=0", cw, step, F0);
    end
    for (int i = 1; i < 3; i++) begin
      tick();
      #1;
      n_checks++;
      if ((cw & (AL | BL)) !== 15'h0 || step !== 3'(i)) begin
        n_fail++;
        $display("FAIL rstmid_noload%0d: cw=%h step=%0d, expected no a/b load, step=%0d",
                 i, cw, step, i);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lda();
    test_add_sub();
    test_jc();
    test_short_ops();
    test_hlt();
    test_sta_pause();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
